// File: rtl/control_unit.sv
// control_unit: hardwired sequencer for the datapath.
// Fetch runs T0-T2 and execute runs T3-T7. The instruction is decoded from IR[OP_MSB -: 5].
// Memory steps (T1, ld T6, st T7) are held for MEM_WAIT+1 clocks by a wait counter.
// Optional feature macro: CTRL_MULDIV_EN (mul/div execute sequence; decoded as nop when undefined).
// Handshake: none. Every strobe is a pure decode of (state, opcode, CON, wait count).
// Current state is exported on dbg_state so checkers can bind to it.
module control_unit #(
    parameter int MEM_WAIT = 0,
    parameter int OP_MSB   = 31
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        stop,
    output logic        run,
    output logic        PCout, Zlowout, Zhighout, MDRout, Cout,
    output logic        IN_Portout, LOout, HIout, BAout, Rout,
    output logic        MARIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn,
    output logic        CIn, InIn, OutIn, ZIn, CONIn, RIn, IncPC,
    output logic        Gra, Grb, Grc,
    output logic        read, write,
    output logic        add, subtract, andSignal, orSignal, multiply, divide,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
        ST_STOPPED, ST_HALTED
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state, next_state;
    logic [2:0] wait_cnt;
    logic [4:0] opcode;
    logic       is_rtype, is_imm, is_ld, is_st, is_br, is_halt, is_muldiv;
    logic       mem_step, mem_done;
    logic       unused_ir;

    assign opcode    = IR[OP_MSB -: 5];
    assign unused_ir = ^IR;
    assign dbg_state = state;

    assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
    assign is_imm   = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_ld    = (opcode == OP_LD);
    assign is_st    = (opcode == OP_ST);
    assign is_br    = (opcode == OP_BR);
    assign is_halt  = (opcode == OP_HALT);
`ifdef CTRL_MULDIV_EN
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
`else
    assign is_muldiv = 1'b0;
`endif

    assign mem_step = (state == ST_T1) || (state == ST_T6 && is_ld) || (state == ST_T7 && is_st);
    assign mem_done = (wait_cnt == 3'(MEM_WAIT));

    // State register and memory wait counter; counter is zero whenever a memory step is entered.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_RESET;
            wait_cnt <= 3'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= (mem_step && !mem_done) ? wait_cnt + 3'd1 : 3'd0;
        end
    end

    // Next-state and strobe decode; every strobe defaults low.
    always_comb begin
        next_state = state;
        {PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout, BAout, Rout} = '0;
        {MARIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn, RIn, IncPC} = '0;
        {Gra, Grb, Grc, read, write} = '0;
        {add, subtract, andSignal, orSignal, multiply, divide} = '0;
        run = (state >= ST_T0) && (state <= ST_T7);

        unique case (state)
            ST_RESET: next_state = ST_T0;
            // IncPC selects the PC incrementer, so no ALU op strobe in T0.
            ST_T0: begin
                {PCout, MARIn, IncPC, ZIn} = 4'b1111;
                next_state = ST_T1;
            end
            ST_T1: begin
                {Zlowout, PCIn, read, MDRIn} = 4'b1111;
                if (mem_done) next_state = ST_T2;
            end
            ST_T2: begin
                {MDRout, IRIn} = 2'b11;
                next_state = ST_T3;
            end
            ST_T3: begin
                next_state = ST_T4;
                if (is_rtype || is_imm)     {Grb, Rout, YIn} = 3'b111;
                else if (is_ld || is_st)    {Grb, BAout, YIn} = 3'b111;
                else if (is_br)             {Gra, Rout, CONIn} = 3'b111;
                else if (is_muldiv)         {Gra, Rout, YIn} = 3'b111;
                else if (is_halt)           next_state = ST_HALTED;
                else                        next_state = stop ? ST_STOPPED : ST_T0;
            end
            ST_T4: begin
                next_state = ST_T5;
                if (is_rtype)               {Grc, Rout, ZIn} = 3'b111;
                else if (is_imm)            {Cout, ZIn} = 2'b11;
                else if (is_ld || is_st)    {Cout, add, ZIn} = 3'b111;
                else if (is_br)             {PCout, YIn} = 2'b11;
                else if (is_muldiv) begin
                    {Grb, Rout, ZIn} = 3'b111;
                    multiply = (opcode == OP_MUL);
                    divide   = (opcode == OP_DIV);
                end
                if (is_rtype || is_imm) begin
                    add       = (opcode == OP_ADD) || (opcode == OP_ADDI);
                    subtract  = (opcode == OP_SUB);
                    andSignal = (opcode == OP_AND) || (opcode == OP_ANDI);
                    orSignal  = (opcode == OP_OR)  || (opcode == OP_ORI);
                end
            end
            ST_T5: begin
                next_state = ST_T6;
                if (is_rtype || is_imm) begin
                    {Zlowout, Gra, RIn} = 3'b111;
                    next_state = stop ? ST_STOPPED : ST_T0;
                end
                else if (is_ld || is_st)    {Zlowout, MARIn} = 2'b11;
                else if (is_br)             {Cout, add, ZIn} = 3'b111;
                else if (is_muldiv)         {Zlowout, LoIn} = 2'b11;
            end
            ST_T6: begin
                next_state = stop ? ST_STOPPED : ST_T0;
                if (is_ld) begin
                    {read, MDRIn} = 2'b11;
                    next_state = mem_done ? ST_T7 : ST_T6;
                end
                else if (is_st) begin
                    {Gra, Rout, MDRIn} = 3'b111;
                    next_state = ST_T7;
                end
                else if (is_br) begin
                    Zlowout = CON;
                    PCIn    = CON;
                end
                else if (is_muldiv)         {Zhighout, HiIn} = 2'b11;
            end
            ST_T7: begin
                next_state = stop ? ST_STOPPED : ST_T0;
                if (is_ld)                  {MDRout, Gra, RIn} = 3'b111;
                else if (is_st) begin
                    write = 1'b1;
                    if (!mem_done) next_state = ST_T7;
                end
            end
            ST_STOPPED: if (!stop) next_state = ST_T0;
            ST_HALTED:  next_state = ST_HALTED;
            default:    next_state = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed table, hand sequences and random instruction streams for control_unit.
module tb_control_unit;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic clr, stop, CON;
    logic [31:0] IR;
    logic run, PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout, BAout, Rout;
    logic MARIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn, RIn, IncPC;
    logic Gra, Grb, Grc, read, write, add, subtract, andSignal, orSignal, multiply, divide;
    logic [3:0] dbg_state;
    logic [35:0] obs;

    // Clock
    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT(MW), .OP_MSB(31)) dut (
        .clk(clk), .clr(clr), .IR(IR), .CON(CON), .stop(stop), .run(run),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
        .IN_Portout(IN_Portout), .LOout(LOout), .HIout(HIout), .BAout(BAout), .Rout(Rout),
        .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn), .HiIn(HiIn),
        .LoIn(LoIn), .CIn(CIn), .InIn(InIn), .OutIn(OutIn), .ZIn(ZIn), .CONIn(CONIn),
        .RIn(RIn), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .read(read), .write(write),
        .add(add), .subtract(subtract), .andSignal(andSignal), .orSignal(orSignal),
        .multiply(multiply), .divide(divide), .dbg_state(dbg_state)
    );

    assign obs = {run, PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout, BAout,
                  Rout, MARIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn,
                  RIn, IncPC, Gra, Grb, Grc, read, write, add, subtract, andSignal, orSignal,
                  multiply, divide};

    localparam logic [35:0] ONE = 36'h1;
    localparam logic [35:0] RUN = ONE << 35, PCOUT = ONE << 34, ZLOWOUT = ONE << 33;
    localparam logic [35:0] ZHIGHOUT = ONE << 32, MDROUT = ONE << 31, COUT = ONE << 30;
    localparam logic [35:0] BAOUT = ONE << 26, ROUT = ONE << 25, MARIN = ONE << 24;
    localparam logic [35:0] PCIN = ONE << 23, MDRIN = ONE << 22, IRIN = ONE << 21;
    localparam logic [35:0] YIN = ONE << 20, HIIN = ONE << 19, LOIN = ONE << 18;
    localparam logic [35:0] ZIN = ONE << 14, CONIN = ONE << 13, RIN = ONE << 12;
    localparam logic [35:0] INCPC = ONE << 11, GRA = ONE << 10, GRB = ONE << 9, GRC = ONE << 8;
    localparam logic [35:0] READ = ONE << 7, WRITE = ONE << 6, ADD = ONE << 5, SUB = ONE << 4;
    localparam logic [35:0] AND_S = ONE << 3, OR_S = ONE << 2, MUL = ONE << 1, DIV = ONE;
    localparam logic [35:0] T0V = RUN | PCOUT | MARIN | INCPC | ZIN;

    int total = 0;
    int bad = 0;
    logic [35:0] exp_q[$];

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        con;
        int          exp_cycles;
        logic [35:0] exp_last;
    } vec_t;
    vec_t tbl[10];

    task automatic check_vec(input string name, input logic [35:0] got, input logic [35:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Reference model: one entry per clock, memory steps repeated MW+1 times.
    task automatic push_step(input logic [35:0] v, input bit mem);
        int n;
        n = mem ? MW + 1 : 1;
        for (int i = 0; i < n; i++) exp_q.push_back(RUN | v);
    endtask

    task automatic build_expected(input logic [4:0] op, input logic con);
        logic [35:0] alu;
        exp_q.delete();
        push_step(PCOUT | MARIN | INCPC | ZIN, 0);
        push_step(ZLOWOUT | PCIN | READ | MDRIN, 1);
        push_step(MDROUT | IRIN, 0);
        case (op)
            5'b00011, 5'b01100: alu = ADD;
            5'b00100:           alu = SUB;
            5'b00101, 5'b01101: alu = AND_S;
            default:            alu = OR_S;
        endcase
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                push_step(GRB | ROUT | YIN, 0);
                push_step(GRC | ROUT | alu | ZIN, 0);
                push_step(ZLOWOUT | GRA | RIN, 0);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                push_step(GRB | ROUT | YIN, 0);
                push_step(COUT | alu | ZIN, 0);
                push_step(ZLOWOUT | GRA | RIN, 0);
            end
            5'b00000, 5'b00010: begin
                push_step(GRB | BAOUT | YIN, 0);
                push_step(COUT | ADD | ZIN, 0);
                push_step(ZLOWOUT | MARIN, 0);
                if (op == 5'b00000) begin
                    push_step(READ | MDRIN, 1);
                    push_step(MDROUT | GRA | RIN, 0);
                end else begin
                    push_step(GRA | ROUT | MDRIN, 0);
                    push_step(WRITE, 1);
                end
            end
            5'b10010: begin
                push_step(GRA | ROUT | CONIN, 0);
                push_step(PCOUT | YIN, 0);
                push_step(COUT | ADD | ZIN, 0);
                push_step(con ? (ZLOWOUT | PCIN) : 36'h0, 0);
            end
`ifdef CTRL_MULDIV_EN
            5'b01111, 5'b10000: begin
                push_step(GRA | ROUT | YIN, 0);
                push_step(GRB | ROUT | ((op == 5'b01111) ? MUL : DIV) | ZIN, 0);
                push_step(ZLOWOUT | LOIN, 0);
                push_step(ZHIGHOUT | HIIN, 0);
            end
`endif
            default: push_step(36'h0, 0);
        endcase
    endtask

    // Runs one instruction from a T0 boundary; optional stop request held stop_cycles clocks.
    task automatic run_instr(input logic [31:0] ir, input logic con, input int stop_cycles,
                             input string tag);
        int n;
        logic [35:0] e;
        IR = ir;
        CON = con;
        build_expected(ir[31:27], con);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check_vec($sformatf("%s_step%0d", tag, i), obs, e);
            if (i == n - 1 && stop_cycles > 0) stop = 1'b1;
            @(negedge clk);
        end
        for (int k = 0; k < stop_cycles; k++) begin
            check_vec($sformatf("%s_stopped%0d", tag, k), obs, 36'h0);
            if (k == stop_cycles - 1) stop = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ops[15];
        logic [35:0] last;
        int cycles;
        logic [4:0] op;

        tbl[0] = '{"add",    32'h18918000, 1'b0, 8,  RUN | ZLOWOUT | GRA | RIN};
        tbl[1] = '{"sub",    32'h20000000, 1'b0, 8,  RUN | ZLOWOUT | GRA | RIN};
        tbl[2] = '{"ori",    32'h70000000, 1'b1, 8,  RUN | ZLOWOUT | GRA | RIN};
        tbl[3] = '{"ld",     32'h00800000, 1'b0, 12, RUN | MDROUT | GRA | RIN};
        tbl[4] = '{"st",     32'h10000000, 1'b0, 12, RUN | WRITE};
        tbl[5] = '{"br_c0",  32'h90000000, 1'b0, 9,  RUN};
        tbl[6] = '{"br_c1",  32'h90000000, 1'b1, 9,  RUN | ZLOWOUT | PCIN};
        tbl[7] = '{"nop",    32'hD0000000, 1'b0, 6,  RUN};
        tbl[8] = '{"undef",  32'hF8000000, 1'b0, 6,  RUN};
`ifdef CTRL_MULDIV_EN
        tbl[9] = '{"mul",    32'h78000000, 1'b0, 9,  RUN | ZHIGHOUT | HIIN};
`else
        tbl[9] = '{"mul",    32'h78000000, 1'b0, 6,  RUN};
`endif
        ops = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100,
                5'b01101, 5'b01110, 5'b01111, 5'b10000, 5'b10010, 5'b11010, 5'b11111, 5'b00001};

        // Reset: two clocks of clr, then T0
        clr = 1'b1; stop = 1'b0; CON = 1'b0; IR = 32'h0;
        @(negedge clk);
        check_vec("reset_c1", obs, 36'h0);
        @(negedge clk);
        check_vec("reset_c2", obs, 36'h0);
        clr = 1'b0;
        @(negedge clk);
        check_vec("t0_after_reset", obs, T0V);

        // Directed table: instruction length and final-step strobes
        for (int t = 0; t < 10; t++) begin
            IR = tbl[t].ir;
            CON = tbl[t].con;
            cycles = 0;
            last = '0;
            do begin
                last = obs;
                cycles++;
                @(negedge clk);
            end while (obs !== T0V && cycles < 40);
            check_int({tbl[t].name, "_len"}, cycles, tbl[t].exp_cycles);
            check_vec({tbl[t].name, "_last"}, last, tbl[t].exp_last);
        end

        // clr during ld T5: abort, RESET, refetch
        IR = 32'h00800000;
        CON = 1'b0;
        build_expected(5'b00000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_vec($sformatf("ld_abort_step%0d", i), obs, exp_q.pop_front());
            if (i == 7) clr = 1'b1;
            @(negedge clk);
        end
        check_vec("ld_abort_reset", obs, 36'h0);
        clr = 1'b0;
        @(negedge clk);
        run_instr(32'h18918000, 1'b0, 0, "refetch_add");

        // Stop at boundary, then resume
        run_instr(32'h28000000, 1'b0, 3, "and_stop");
        run_instr(32'h00000000, 1'b0, 1, "ld_stop");

        // Random instruction stream against the model
        for (int r = 0; r < 60; r++) begin
            op = ops[$urandom_range(0, 14)];
            run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      $sformatf("rnd%0d", r));
        end

        // halt: parks in HALTED until clr
        run_instr(32'hD8000000, 1'b0, 0, "halt");
        for (int h = 0; h < 20; h++) begin
            check_vec($sformatf("halted%0d", h), obs, 36'h0);
            stop = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        stop = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        check_vec("halt_clr", obs, 36'h0);
        clr = 1'b0;
        @(negedge clk);
        check_vec("halt_refetch", obs, T0V);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
